// File: rtl/la_clkgatectl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : la_clkgatectl (with leaf cell la_clkicgand)
// Description : Per-channel idle-driven clock gating controller. Each channel
//               runs a RUN/COOL/OFF state machine with a hold-off countdown.
//               It drives one latch-based integrated clock gate.
//               Optional build macro LA_CLKGATECTL_STATS_EN adds the gcount
//               port, which holds saturating per-channel OFF-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// la_clkicgand : latch-based AND clock gate. The enable is captured while clk
// is low, so the enable cannot change during the high phase.
// ----------------------------------------------------------------------------
module la_clkicgand #(
  parameter PROP = "DEFAULT"
) (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic eclk
);

  // A technology mapping flow replaces this behavioural body with the
  // library gate that PROP names. An empty property leaves the clock ungated.
  if ($bits(PROP) > 0) begin : g_icg_behav
    logic r_en_l;

    // Transparent-low enable latch; holds steady through the high phase
    always_latch begin
      if (!clk) begin
        r_en_l <= en | te;
      end
    end

    assign eclk = clk & r_en_l;
  end else begin : g_icg_bypass
    logic w_unused;
    assign w_unused = en | te;
    assign eclk     = clk;
  end

endmodule

// ----------------------------------------------------------------------------
// la_clkgatectl : top level
// ----------------------------------------------------------------------------
module la_clkgatectl #(
  parameter int N     = 4,
  parameter int HOLDW = 8,
  parameter     PROP  = "DEFAULT"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             te,
  input  logic [N-1:0]     busy,
  input  logic [HOLDW-1:0] hold,
  output logic [N-1:0]     eclk,
  output logic [N-1:0]     ready,
  output logic [N-1:0]     gated
`ifdef LA_CLKGATECTL_STATS_EN
  ,
  output logic [N*16-1:0]  gcount
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_COOL = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [HOLDW-1:0] c_CNT_ONE = HOLDW'(1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t           r_state;
    logic [HOLDW-1:0] r_cnt;
    logic             r_ready;
    logic             r_gated;
    logic             w_en;

    // Channel FSM and hold-off countdown. ready/gated are registered on
    // the same edge as the state, from the next state and the sampled te.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
        r_ready <= 1'b1;
        r_gated <= 1'b0;
      end else begin
        r_ready <= 1'b0;
        r_gated <= 1'b0;
        case (r_state)
          ST_RUN: begin
            if (busy[i]) begin
              r_ready <= 1'b1;
            end else if (hold == '0) begin
              r_state <= ST_OFF;
              r_gated <= ~te;
            end else begin
              r_state <= ST_COOL;
              r_cnt   <= hold;
            end
          end
          ST_COOL: begin
            if (busy[i]) begin
              r_state <= ST_RUN;
              r_cnt   <= '0;
              r_ready <= 1'b1;
            end else if (r_cnt == c_CNT_ONE) begin
              r_state <= ST_OFF;
              r_cnt   <= '0;
              r_gated <= ~te;
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
          ST_OFF: begin
            if (busy[i]) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end else begin
              r_gated <= ~te;
            end
          end
          default: begin
            // Unreachable encoding: recover to a running clock
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end

    assign w_en     = (r_state != ST_OFF);
    assign ready[i] = r_ready;
    assign gated[i] = r_gated;

    la_clkicgand #(
      .PROP (PROP)
    ) u_icg (
      .clk  (clk),
      .en   (w_en),
      .te   (te),
      .eclk (eclk[i])
    );

`ifdef LA_CLKGATECTL_STATS_EN
    logic [15:0] r_gcnt;

    // Saturating count of cycles spent gated (OFF with test enable low)
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_gcnt <= '0;
      end else if ((r_state == ST_OFF) && !te && (r_gcnt != 16'hFFFF)) begin
        r_gcnt <= r_gcnt + 16'd1;
      end
    end

    assign gcount[i*16 +: 16] = r_gcnt;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_la_clkgatectl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_la_clkgatectl
// Description : Self-checking bench for la_clkgatectl. The reference model
//               tracks idle run length per channel against the hold value
//               captured when the idle run began.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_clkgatectl;

  localparam int N     = 4;
  localparam int HOLDW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             te;
  logic [N-1:0]     busy;
  logic [HOLDW-1:0] hold;
  wire  [N-1:0]     eclk;
  wire  [N-1:0]     ready;
  wire  [N-1:0]     gated;
`ifdef LA_CLKGATECTL_STATS_EN
  wire  [N*16-1:0]  gcount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: consecutive idle edges, hold captured at idle start,
  // and the gated-cycle counter
  int m_idle  [N];
  int m_lhold [N];
  int m_gc    [N];

  always #5 clk = ~clk;

  la_clkgatectl #(
    .N     (N),
    .HOLDW (HOLDW),
    .PROP  ("DEFAULT")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .te    (te),
    .busy  (busy),
    .hold  (hold),
    .eclk  (eclk),
    .ready (ready),
    .gated (gated)
`ifdef LA_CLKGATECTL_STATS_EN
    ,
    .gcount(gcount)
`endif
  );

  // A channel is off once its idle run exceeds the hold it started with
  function automatic bit m_off(int i);
    return m_idle[i] > m_lhold[i];
  endfunction

  // Advance model and DUT by one rising edge; returns at edge + 1ns with
  // the expected eclk pulse, ready and gated for that edge
  task automatic cycle(output logic [N-1:0] xp, output logic [N-1:0] xr,
                       output logic [N-1:0] xg);
    for (int i = 0; i < N; i++) begin
      xp[i] = !m_off(i) || te;
      if (m_off(i) && !te && m_gc[i] < 65535) m_gc[i]++;
      if (busy[i]) begin
        m_idle[i] = 0;
      end else begin
        if (m_idle[i] == 0) m_lhold[i] = int'(hold);
        if (m_idle[i] <= m_lhold[i]) m_idle[i]++;
      end
      xr[i] = (m_idle[i] == 0);
      xg[i] = m_off(i) && !te;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously, check its immediate effect, release in low phase
  task automatic apply_reset(string name);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ready !== 4'b1111) begin
      n_errors++;
      $display("FAIL %s ready: got %b expected 1111", name, ready);
    end
    n_checks++;
    if (gated !== 4'b0000) begin
      n_errors++;
      $display("FAIL %s gated: got %b expected 0000", name, gated);
    end
    for (int i = 0; i < N; i++) begin
      m_idle[i]  = 0;
      m_lhold[i] = 0;
      m_gc[i]    = 0;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (eclk !== 4'b1111) begin
      n_errors++;
      $display("FAIL %s eclk in reset: got %b expected 1111", name, eclk);
    end
`ifdef LA_CLKGATECTL_STATS_EN
    n_checks++;
    if (gcount !== '0) begin
      n_errors++;
      $display("FAIL %s gcount: got %h expected 0", name, gcount);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  // hold=3, busy[0] drops: COOL for three edges, OFF on the fourth
  task automatic test_cool_off();
    logic [N-1:0] xp, xr, xg;
    hold = 8'd3; busy = 4'b1111; te = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) busy[0] = 1'b0;
      cycle(xp, xr, xg);
      n_checks++;
      if (eclk !== xp || ready !== xr || gated !== xg) begin
        n_errors++;
        $display("FAIL cool_off k=%0d: eclk/ready/gated=%b/%b/%b expected %b/%b/%b",
                 k, eclk, ready, gated, xp, xr, xg);
      end
      if (k == 3) begin
        n_checks++;
        if (ready !== 4'b1110) begin
          n_errors++;
          $display("FAIL cool_off enter ready: got %b expected 1110", ready);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (gated !== 4'b0001 || eclk[0] !== 1'b1) begin
          n_errors++;
          $display("FAIL cool_off last pulse: gated=%b eclk=%b expected 0001/xxx1", gated, eclk);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (eclk !== 4'b1110) begin
          n_errors++;
          $display("FAIL cool_off stopped: eclk=%b expected 1110", eclk);
        end
      end
    end
  endtask

  // hold=0: immediate OFF, wake returns pulses one edge after RUN
  task automatic test_wake();
    logic [N-1:0] xp, xr, xg;
    hold = 8'd0; busy = 4'b1111; te = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) busy[1] = 1'b0;
      if (k == 4) busy[1] = 1'b1;
      cycle(xp, xr, xg);
      n_checks++;
      if (eclk !== xp || ready !== xr || gated !== xg) begin
        n_errors++;
        $display("FAIL wake k=%0d: eclk/ready/gated=%b/%b/%b expected %b/%b/%b",
                 k, eclk, ready, gated, xp, xr, xg);
      end
      if (k == 1 && gated !== 4'b0010) begin
        n_errors++;
        $display("FAIL wake off: gated=%b expected 0010", gated);
      end
      if (k == 1) n_checks++;
      if (k == 4) begin
        n_checks++;
        if (ready !== 4'b1111 || eclk[1] !== 1'b0) begin
          n_errors++;
          $display("FAIL wake run: ready=%b eclk=%b expected 1111/xx0x", ready, eclk);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (eclk !== 4'b1111) begin
          n_errors++;
          $display("FAIL wake pulse: eclk=%b expected 1111", eclk);
        end
      end
    end
  endtask

  // Short idle inside hold window never gates channel 2
  task automatic test_short_idle();
    logic [N-1:0] xp, xr, xg;
    hold = 8'd4; busy = 4'b1111; te = 1'b0;
    for (int k = 0; k < 6; k++) begin
      busy[2] = !(k == 1 || k == 2);
      cycle(xp, xr, xg);
      n_checks++;
      if (gated[2] !== 1'b0 || eclk[2] !== 1'b1 || ready !== xr) begin
        n_errors++;
        $display("FAIL short_idle k=%0d: gated=%b eclk=%b ready=%b expected xx0x/x1xx/%b",
                 k, gated, eclk, ready, xr);
      end
    end
  endtask

  // te overrides gating without disturbing the state machines
  task automatic test_te();
    logic [N-1:0] xp, xr, xg;
    hold = 8'd0; busy = 4'b0000; te = 1'b0;
    for (int k = 0; k < 8; k++) begin
      te = (k >= 2 && k < 5);
      cycle(xp, xr, xg);
      n_checks++;
      if (eclk !== xp || ready !== xr || gated !== xg) begin
        n_errors++;
        $display("FAIL te k=%0d: eclk/ready/gated=%b/%b/%b expected %b/%b/%b",
                 k, eclk, ready, gated, xp, xr, xg);
      end
      if (k == 3) begin
        n_checks++;
        if (eclk !== 4'b1111 || gated !== 4'b0000) begin
          n_errors++;
          $display("FAIL te forced: eclk=%b gated=%b expected 1111/0000", eclk, gated);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (eclk !== 4'b0000 || gated !== 4'b1111 || ready !== 4'b0000) begin
          n_errors++;
          $display("FAIL te resume: eclk=%b gated=%b ready=%b expected 0000/1111/0000",
                   eclk, gated, ready);
        end
      end
    end
  endtask

  // Reset lands two cycles into a hold=5 countdown
  task automatic test_reset_mid_cool();
    logic [N-1:0] xp, xr, xg;
    hold = 8'd5; busy = 4'b1111; te = 1'b0;
    cycle(xp, xr, xg);
    busy = 4'b0000;
    for (int k = 0; k < 3; k++) cycle(xp, xr, xg);
    n_checks++;
    if (ready !== 4'b0000 || gated !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_cool pre: ready=%b gated=%b expected 0000/0000", ready, gated);
    end
    apply_reset("mid_cool");
    busy = 4'b1111;
  endtask

  // Random busy/te/hold traffic with occasional asynchronous resets
  task automatic test_random();
    logic [N-1:0] xp, xr, xg;
    for (int k = 0; k < 600; k++) begin
      busy = 4'($urandom);
      if ($urandom_range(0, 3) != 0) busy = busy | 4'($urandom);
      te = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 24) == 0) hold = 8'($urandom_range(0, 6));
      cycle(xp, xr, xg);
      n_checks++;
      if (eclk !== xp || ready !== xr || gated !== xg) begin
        n_errors++;
        $display("FAIL random k=%0d: eclk/ready/gated=%b/%b/%b expected %b/%b/%b",
                 k, eclk, ready, gated, xp, xr, xg);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (eclk !== 4'b0000) begin
        n_errors++;
        $display("FAIL random low phase k=%0d: eclk=%b expected 0000", k, eclk);
      end
      if ($urandom_range(0, 149) == 0) apply_reset("random");
    end
  endtask

`ifdef LA_CLKGATECTL_STATS_EN
  // Channel 3 held OFF long enough to saturate its counter
  task automatic test_stats();
    logic [N-1:0] xp, xr, xg;
    logic [15:0]  exp_gc;
    te = 1'b0; hold = 8'd0; busy = 4'b0111;
    for (int k = 0; k < 70000; k++) cycle(xp, xr, xg);
    for (int i = 0; i < N; i++) begin
      exp_gc = 16'(m_gc[i]);
      n_checks++;
      if (gcount[i*16 +: 16] !== exp_gc) begin
        n_errors++;
        $display("FAIL stats ch%0d: got %h expected %h", i, gcount[i*16 +: 16], exp_gc);
      end
    end
    n_checks++;
    if (gcount[63:48] !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL stats saturate: got %h expected ffff", gcount[63:48]);
    end
    apply_reset("stats");
  endtask
`endif

  initial begin
    reset = 1'b1;
    te    = 1'b0;
    busy  = 4'b1111;
    hold  = 8'd0;
    test_reset();
    test_cool_off();
    test_wake();
    test_short_idle();
    test_te();
    test_reset_mid_cool();
    test_random();
`ifdef LA_CLKGATECTL_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
